// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FWFT FIFO and its RAM.
package fifo_pkg;

  // Total capacity in words, including the output stage.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'(1) << addr_width;
  endfunction

  // Width of a counter that must hold 0..DEPTH inclusive.
  function automatic int unsigned fifo_count_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage : fifo_pkg

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port with enable.
module sdp_bram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register is cleared on reset; it holds its value when not read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : sdp_bram

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; the RAM read register is the output stage.
module sync_fwft_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  output logic                                  fifo_write_full,
  input  logic [DATA_WIDTH-1:0]                 fifo_write_data,
  input  logic                                  fifo_write_wren,
  output logic                                  fifo_read_empty,
  output logic [DATA_WIDTH-1:0]                 fifo_read_data,
  input  logic                                  fifo_read_rden,
  output logic [fifo_count_width(ADDR_WIDTH)-1:0] data_count,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned CW    = fifo_count_width(ADDR_WIDTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ram_count_q, ram_count_d;
  logic [CW-1:0] data_count_q, data_count_d;
  logic          out_valid_q, out_valid_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_accept_c;
  logic pop_accept_c;
  logic prefetch_c;

  // Acceptance uses only registered flags, so no request-to-flag combinational path.
  assign wr_accept_c  = fifo_write_wren && !full_q;
  assign pop_accept_c = fifo_read_rden && out_valid_q;
  assign prefetch_c   = (ram_count_q != '0) && (!out_valid_q || pop_accept_c);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_count_d  = ram_count_q;
    data_count_d = data_count_q;
    out_valid_d  = out_valid_q;
    full_d       = full_q;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;

    if (wr_accept_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    // A refill on the same edge as a pop keeps the output stage occupied.
    if (prefetch_c) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_valid_d = 1'b1;
    end else if (pop_accept_c) begin
      out_valid_d = 1'b0;
    end

    ram_count_d  = ram_count_q + CW'(wr_accept_c) - CW'(prefetch_c);
    data_count_d = data_count_q + CW'(wr_accept_c) - CW'(pop_accept_c);
    full_d       = (data_count_d == CW'(DEPTH));

    overflow_d   = fifo_write_wren && full_q;
    underflow_d  = fifo_read_rden && !out_valid_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      data_count_q <= '0;
      out_valid_q  <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      data_count_q <= data_count_d;
      out_valid_q  <= out_valid_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Write and prefetch never collide: prefetch needs words already in RAM.
  sdp_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (aclk),
    .rst_n     (aresetn),
    .wr_en_i   (wr_accept_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (fifo_write_data),
    .rd_en_i   (prefetch_c),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (fifo_read_data)
  );

  assign fifo_write_full = full_q;
  assign fifo_read_empty = !out_valid_q;
  assign data_count      = data_count_q;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;

endmodule : sync_fwft_fifo

// File: tb/tb_sync_fwft_fifo.sv
// Directed self-checking bench for sync_fwft_fifo at ADDR_WIDTH=4 (DEPTH=16).
module tb_sync_fwft_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          aclk;
  logic          aresetn;
  logic          full;
  logic [DW-1:0] wdata;
  logic          wren;
  logic          empty;
  logic [DW-1:0] rdata;
  logic          rden;
  logic [AW:0]   data_count;
  logic          overflow;
  logic          underflow;

  int n_checks;
  int n_fail;

  sync_fwft_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .fifo_write_full (full),
    .fifo_write_data (wdata),
    .fifo_write_wren (wren),
    .fifo_read_empty (empty),
    .fifo_read_data  (rdata),
    .fifo_read_rden  (rden),
    .data_count      (data_count),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int exp_val;
    int pops;
    int order_errs;
    int gap_errs;
    int cnt_errs;
    int uf_pulses;

    n_checks = 0;
    n_fail   = 0;
    aresetn  = 1'b0;
    wren     = 1'b0;
    rden     = 1'b0;
    wdata    = '0;

    #12;
    aresetn = 1'b1;
    step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(data_count), 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);

    // Single word latency
    wren = 1'b1; wdata = 32'hDEADBEEF;
    step();
    wren = 1'b0;
    check("single_cnt_N", 32'(data_count), 32'd1);
    check("single_empty_N", 32'(empty), 32'd1);
    step();
    check("single_empty_N1", 32'(empty), 32'd0);
    check("single_data_N1", rdata, 32'hDEADBEEF);
    rden = 1'b1;
    step();
    rden = 1'b0;
    check("single_pop_empty", 32'(empty), 32'd1);
    check("single_pop_cnt", 32'(data_count), 32'd0);

    // Fill with 0..15, then 16 is rejected
    for (int i = 0; i <= 16; i++) begin
      wren = 1'b1; wdata = 32'(i);
      step();
      if (i == 15) begin
        check("fill_full", 32'(full), 32'd1);
        check("fill_cnt16", 32'(data_count), 32'd16);
        check("fill_no_ovf", 32'(overflow), 32'd0);
      end
    end
    wren = 1'b0;
    check("fill_ovf_pulse", 32'(overflow), 32'd1);
    check("fill_cnt_after_rej", 32'(data_count), 32'd16);
    step();
    check("fill_ovf_single", 32'(overflow), 32'd0);
    check("fill_head", rdata, 32'd0);

    // Full + write + pop: pop accepted, write rejected
    wren = 1'b1; rden = 1'b1; wdata = 32'h99;
    step();
    wren = 1'b0; rden = 1'b0;
    check("fullsim_ovf", 32'(overflow), 32'd1);
    check("fullsim_cnt", 32'(data_count), 32'd15);
    check("fullsim_full", 32'(full), 32'd0);

    // Drain the remaining 1..15
    order_errs = 0;
    for (int j = 1; j <= 15; j++) begin
      if (empty !== 1'b0 || rdata !== 32'(j)) order_errs++;
      rden = 1'b1;
      step();
    end
    rden = 1'b0;
    check("drain_order_errs", 32'(order_errs), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_cnt", 32'(data_count), 32'd0);

    // Empty + write + pop: write accepted, pop rejected
    wren = 1'b1; rden = 1'b1; wdata = 32'h55;
    step();
    wren = 1'b0; rden = 1'b0;
    check("emptysim_udf", 32'(underflow), 32'd1);
    check("emptysim_cnt", 32'(data_count), 32'd1);
    step();
    check("emptysim_data", rdata, 32'h55);
    check("emptysim_udf_clr", 32'(underflow), 32'd0);
    rden = 1'b1;
    step();
    rden = 1'b0;
    check("emptysim_drained", 32'(empty), 32'd1);

    // Five rejected pops on an empty FIFO
    uf_pulses = 0;
    rden = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (underflow === 1'b1) uf_pulses++;
    end
    rden = 1'b0;
    check("udf_pulses", 32'(uf_pulses), 32'd5);
    check("udf_cnt", 32'(data_count), 32'd0);
    check("udf_data_held", rdata, 32'h55);
    step();
    check("udf_clr", 32'(underflow), 32'd0);

    // Streaming: wren and rden held high for 1000 cycles from empty
    exp_val = 0; pops = 0; order_errs = 0; gap_errs = 0; cnt_errs = 0;
    for (int k = 0; k < 1000; k++) begin
      wren = 1'b1; rden = 1'b1; wdata = 32'(k);
      if (empty === 1'b0) begin
        if (rdata !== 32'(exp_val)) order_errs++;
        exp_val++;
        pops++;
      end else if (k >= 2) begin
        gap_errs++;
      end
      step();
      if (k >= 1 && data_count !== 5'd2) cnt_errs++;
    end
    wren = 1'b0;
    check("stream_order_errs", 32'(order_errs), 32'd0);
    check("stream_gap_errs", 32'(gap_errs), 32'd0);
    check("stream_cnt_errs", 32'(cnt_errs), 32'd0);
    check("stream_pops", 32'(pops), 32'd998);
    check("stream_tail0", rdata, 32'd998);
    step();
    check("stream_tail1", rdata, 32'd999);
    step();
    rden = 1'b0;
    check("stream_end_empty", 32'(empty), 32'd1);
    check("stream_end_cnt", 32'(data_count), 32'd0);

    // Mid-operation asynchronous reset with 7 words stored
    for (int i = 0; i < 7; i++) begin
      wren = 1'b1; wdata = 32'h100 + 32'(i);
      step();
    end
    wren = 1'b0;
    step();
    check("pre_rst_cnt", 32'(data_count), 32'd7);
    #2 aresetn = 1'b0;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_cnt", 32'(data_count), 32'd0);
    check("async_rst_data", rdata, 32'd0);
    #2 aresetn = 1'b1;
    step();
    wren = 1'b1; wdata = 32'hA5;
    step();
    wren = 1'b0;
    step();
    check("post_rst_data", rdata, 32'hA5);
    check("post_rst_cnt", 32'(data_count), 32'd1);
    rden = 1'b1;
    step();
    rden = 1'b0;
    check("post_rst_empty", 32'(empty), 32'd1);
    step();
    step();
    check("post_rst_no_stale", 32'(empty), 32'd1);
    check("post_rst_cnt0", 32'(data_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fwft_fifo
